// File: rtl/reg_transfer_sequencer_pkg.sv
// Shared definitions for the register-transfer sequencer: register
// selector codes, request opcodes, FSM state encodings and a small
// decode helper used by the sequencer datapath.
package reg_transfer_sequencer_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_SEL_W  = 3;

   localparam logic [2:0] R0_SELECTOR = 3'd0;
   localparam logic [2:0] R1_SELECTOR = 3'd1;
   localparam logic [2:0] R2_SELECTOR = 3'd2;
   localparam logic [2:0] R3_SELECTOR = 3'd3;
   localparam logic [2:0] R4_SELECTOR = 3'd4;
   localparam logic [2:0] R5_SELECTOR = 3'd5;
   localparam logic [2:0] R6_SELECTOR = 3'd6;
   localparam logic [2:0] R7_SELECTOR = 3'd7;

   typedef enum logic [1:0] {
      OP_LDI = 2'd0,
      OP_MOV = 2'd1,
      OP_RD  = 2'd2,
      OP_SWP = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SEL  = 3'd1,
      ST_CAP  = 3'd2,
      ST_WR_A = 3'd3,
      ST_WR_B = 3'd4,
      ST_RESP = 3'd5
   } state_e;

   // Only the two write states may ever qualify a register-file write.
   function automatic logic is_write_state(input state_e s);
      return (s == ST_WR_A) || (s == ST_WR_B);
   endfunction

endpackage

// File: rtl/reg_transfer_sequencer_if.sv
// Bundle of the decoder-side request/response handshake and the
// general_registers select/data lines driven by the sequencer.
// slave is the sequencer's view; master is the decoder plus register
// file side that drives requests and the registered src value.
interface reg_transfer_sequencer_if #(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 3
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [SEL_W-1:0]  req_a;
   logic [SEL_W-1:0]  req_b;
   logic [DATA_W-1:0] req_imm;
   logic [SEL_W-1:0]  src_bus_selector;
   logic [SEL_W-1:0]  dest_bus_selector;
   logic              dest_we;
   logic [DATA_W-1:0] data;
   logic [DATA_W-1:0] src;
   logic              done;
   logic [DATA_W-1:0] rsp_data;
   logic              busy;

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_imm, src,
      output req_ready, src_bus_selector, dest_bus_selector, dest_we,
             data, done, rsp_data, busy
   );

   modport master (
      output req_valid, req_op, req_a, req_b, req_imm, src,
      input  req_ready, src_bus_selector, dest_bus_selector, dest_we,
             data, done, rsp_data, busy
   );
endinterface

// File: rtl/reg_transfer_sequencer.sv
// Control-side master for general_registers. Takes one transfer request
// (load-immediate, move, read, swap) per handshake and walks the register
// file select/data lines through 1-4 cycles. The register file's src
// output has one cycle of latency, so every read spends a SEL cycle
// presenting the selector before the value is usable.
module reg_transfer_sequencer
   import reg_transfer_sequencer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int SEL_W  = DEF_SEL_W
) (
   input logic clk,
   input logic reset,
   reg_transfer_sequencer_if.slave bus
);

   state_e            state;
   state_e            next_state;
   op_e               op_q;
   logic [SEL_W-1:0]  a_q;
   logic [SEL_W-1:0]  b_q;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] tmp_q;
   logic [DATA_W-1:0] rsp_q;

   logic              accept;
   logic [SEL_W-1:0]  src_sel_c;
   logic [SEL_W-1:0]  dest_sel_c;
   logic [DATA_W-1:0] data_c;
   logic              done_c;
   logic [DATA_W-1:0] rsp_live_c;

   assign accept = bus.req_valid && (state == ST_IDLE);

   // State register; reset forces IDLE so every decoded output drops at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Operand capture on accept, first-read capture for swaps, and the
   // response value held from one done to the next.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q  <= OP_LDI;
         a_q   <= '0;
         b_q   <= '0;
         imm_q <= '0;
         tmp_q <= '0;
         rsp_q <= '0;
      end else begin
         if (accept) begin
            op_q  <= op_e'(bus.req_op);
            a_q   <= bus.req_a;
            b_q   <= bus.req_b;
            imm_q <= bus.req_imm;
         end
         if (state == ST_CAP) begin
            tmp_q <= bus.src;
         end
         if (done_c) begin
            rsp_q <= rsp_live_c;
         end
      end
   end

   // Next-state and register-file drive decode; IDLE leaves every line at zero.
   always_comb begin
      next_state = state;
      src_sel_c  = '0;
      dest_sel_c = '0;
      data_c     = '0;
      done_c     = 1'b0;
      rsp_live_c = '0;
      case (state)
         ST_IDLE: begin
            if (bus.req_valid) begin
               if (op_e'(bus.req_op) == OP_LDI) begin
                  next_state = ST_WR_B;
               end else begin
                  next_state = ST_SEL;
               end
            end
         end
         ST_SEL: begin
            src_sel_c = (op_q == OP_MOV) ? b_q : a_q;
            case (op_q)
               OP_MOV:  next_state = ST_WR_B;
               OP_RD:   next_state = ST_RESP;
               OP_SWP:  next_state = ST_CAP;
               default: next_state = ST_IDLE;
            endcase
         end
         ST_CAP: begin
            src_sel_c  = b_q;
            next_state = ST_WR_A;
         end
         ST_WR_A: begin
            dest_sel_c = a_q;
            data_c     = bus.src;
            next_state = ST_WR_B;
         end
         ST_WR_B: begin
            done_c     = 1'b1;
            next_state = ST_IDLE;
            case (op_q)
               OP_LDI: begin
                  dest_sel_c = a_q;
                  data_c     = imm_q;
                  rsp_live_c = imm_q;
               end
               OP_MOV: begin
                  dest_sel_c = a_q;
                  data_c     = bus.src;
                  rsp_live_c = bus.src;
               end
               OP_SWP: begin
                  dest_sel_c = b_q;
                  data_c     = tmp_q;
                  rsp_live_c = tmp_q;
               end
               default: begin
                  rsp_live_c = rsp_q;
               end
            endcase
         end
         ST_RESP: begin
            done_c     = 1'b1;
            rsp_live_c = bus.src;
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   assign bus.req_ready         = (state == ST_IDLE);
   assign bus.busy              = (state != ST_IDLE);
   assign bus.src_bus_selector  = src_sel_c;
   assign bus.dest_bus_selector = dest_sel_c;
   assign bus.dest_we           = is_write_state(state);
   assign bus.data              = data_c;
   assign bus.done              = done_c;
   assign bus.rsp_data          = done_c ? rsp_live_c : rsp_q;

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Directed bench for reg_transfer_sequencer with a behavioural
// general_registers model (registered src output, write on dest_we).
module tb_reg_transfer_sequencer;
   import reg_transfer_sequencer_pkg::*;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fails;

   logic [7:0] regs [8];

   reg_transfer_sequencer_if #(.DATA_W(8), .SEL_W(3)) bus ();

   reg_transfer_sequencer #(.DATA_W(8), .SEL_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      op_e        op;
      logic [2:0] a;
      logic [2:0] b;
      logic [7:0] imm;
      int         lat;
      logic [7:0] rsp;
      int         we_cycles;
   } vec_t;

   vec_t vecs [18];

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Register file model: writes on dest_we, src registered one cycle.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
         bus.src <= 8'h00;
      end else begin
         if (bus.dest_we) regs[bus.dest_bus_selector] <= bus.data;
         bus.src <= regs[bus.src_bus_selector];
      end
   end

   // Global watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it and reports a FAIL line on mismatch.
   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Drive one request, follow it to done and return latency, response and write count.
   task automatic apply_stimulus(input op_e op, input logic [2:0] a, input logic [2:0] b,
                                 input logic [7:0] imm, output int lat,
                                 output logic [7:0] rsp, output int we_cycles);
      int waited;
      lat       = 0;
      rsp       = 8'h00;
      we_cycles = 0;
      waited    = 0;
      @(negedge clk);
      while (!bus.req_ready && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_imm   = imm;
      @(posedge clk);
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         if (bus.dest_we) we_cycles++;
         if (bus.done) begin
            lat = n;
            rsp = bus.rsp_data;
            break;
         end
      end
   endtask

   initial begin
      int         lat;
      int         wec;
      logic [7:0] rsp;
      string      tag;

      n_checks      = 0;
      n_fails       = 0;
      reset         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'd0;
      bus.req_a     = 3'd0;
      bus.req_b     = 3'd0;
      bus.req_imm   = 8'h00;

      vecs[0]  = '{OP_RD,  R3_SELECTOR, R0_SELECTOR, 8'h00, 2, 8'hA5, 0};
      vecs[1]  = '{OP_LDI, R1_SELECTOR, R0_SELECTOR, 8'h3C, 1, 8'h3C, 1};
      vecs[2]  = '{OP_MOV, R6_SELECTOR, R1_SELECTOR, 8'h00, 2, 8'h3C, 1};
      vecs[3]  = '{OP_RD,  R6_SELECTOR, R0_SELECTOR, 8'h00, 2, 8'h3C, 0};
      vecs[4]  = '{OP_RD,  R1_SELECTOR, R0_SELECTOR, 8'h00, 2, 8'h3C, 0};
      vecs[5]  = '{OP_LDI, R2_SELECTOR, R0_SELECTOR, 8'h11, 1, 8'h11, 1};
      vecs[6]  = '{OP_LDI, R5_SELECTOR, R0_SELECTOR, 8'h22, 1, 8'h22, 1};
      vecs[7]  = '{OP_SWP, R2_SELECTOR, R5_SELECTOR, 8'h00, 4, 8'h11, 2};
      vecs[8]  = '{OP_RD,  R2_SELECTOR, R0_SELECTOR, 8'h00, 2, 8'h22, 0};
      vecs[9]  = '{OP_RD,  R5_SELECTOR, R0_SELECTOR, 8'h00, 2, 8'h11, 0};
      vecs[10] = '{OP_LDI, R4_SELECTOR, R0_SELECTOR, 8'h7E, 1, 8'h7E, 1};
      vecs[11] = '{OP_SWP, R4_SELECTOR, R4_SELECTOR, 8'h00, 4, 8'h7E, 2};
      vecs[12] = '{OP_RD,  R4_SELECTOR, R0_SELECTOR, 8'h00, 2, 8'h7E, 0};
      vecs[13] = '{OP_LDI, R7_SELECTOR, R0_SELECTOR, 8'hC3, 1, 8'hC3, 1};
      vecs[14] = '{OP_MOV, R7_SELECTOR, R7_SELECTOR, 8'h00, 2, 8'hC3, 1};
      vecs[15] = '{OP_RD,  R7_SELECTOR, R0_SELECTOR, 8'h00, 2, 8'hC3, 0};
      vecs[16] = '{OP_LDI, R0_SELECTOR, R0_SELECTOR, 8'hFF, 1, 8'hFF, 1};
      vecs[17] = '{OP_RD,  R0_SELECTOR, R0_SELECTOR, 8'h00, 2, 8'hFF, 0};

      // Reset values.
      #12;
      check_output("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check_output("rst_busy",      {31'd0, bus.busy},      32'd0);
      check_output("rst_dest_we",   {31'd0, bus.dest_we},   32'd0);
      check_output("rst_done",      {31'd0, bus.done},      32'd0);
      check_output("rst_data",      {24'd0, bus.data},      32'h00);
      check_output("rst_rsp",       {24'd0, bus.rsp_data},  32'h00);
      check_output("rst_src_sel",   {29'd0, bus.src_bus_selector},  32'd0);
      check_output("rst_dest_sel",  {29'd0, bus.dest_bus_selector}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // LDI R3=A5 with the c1 drive inspected by hand.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_LDI;
      bus.req_a     = R3_SELECTOR;
      bus.req_imm   = 8'hA5;
      @(negedge clk);
      bus.req_valid = 1'b0;
      check_output("ldi_c1_dest_sel", {29'd0, bus.dest_bus_selector}, 32'd3);
      check_output("ldi_c1_data",     {24'd0, bus.data},     32'hA5);
      check_output("ldi_c1_dest_we",  {31'd0, bus.dest_we},  32'd1);
      check_output("ldi_c1_done",     {31'd0, bus.done},     32'd1);
      check_output("ldi_c1_rsp",      {24'd0, bus.rsp_data}, 32'hA5);
      check_output("ldi_c1_ready",    {31'd0, bus.req_ready}, 32'd0);

      // Table-driven transactions.
      for (int i = 0; i < 18; i++) begin
         apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, lat, rsp, wec);
         tag = $sformatf("v%0d", i);
         check_output({tag, "_lat"}, lat, vecs[i].lat);
         check_output({tag, "_rsp"}, {24'd0, rsp}, {24'd0, vecs[i].rsp});
         check_output({tag, "_we"},  wec, vecs[i].we_cycles);
         @(negedge clk);
         check_output({tag, "_hold"}, {24'd0, bus.rsp_data}, {24'd0, vecs[i].rsp});
         check_output({tag, "_idle_ready"}, {31'd0, bus.req_ready}, 32'd1);
      end

      // Back-to-back: LDI R0=5A then MOV R2<-R0 with req_valid held high.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_LDI;
      bus.req_a     = R0_SELECTOR;
      bus.req_imm   = 8'h5A;
      @(negedge clk);
      check_output("b2b_ldi_done", {31'd0, bus.done}, 32'd1);
      bus.req_op = OP_MOV;
      bus.req_a  = R2_SELECTOR;
      bus.req_b  = R0_SELECTOR;
      @(negedge clk);
      check_output("b2b_idle_ready", {31'd0, bus.req_ready}, 32'd1);
      check_output("b2b_idle_we",    {31'd0, bus.dest_we},   32'd0);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check_output("b2b_sel_busy", {31'd0, bus.busy},    32'd1);
      check_output("b2b_sel_we",   {31'd0, bus.dest_we}, 32'd0);
      @(negedge clk);
      check_output("b2b_mov_done", {31'd0, bus.done},              32'd1);
      check_output("b2b_mov_data", {24'd0, bus.data},              32'h5A);
      check_output("b2b_mov_dest", {29'd0, bus.dest_bus_selector}, 32'd2);
      check_output("b2b_mov_we",   {31'd0, bus.dest_we},           32'd1);

      // A request pulsed while a read is in flight must be ignored.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_RD;
      bus.req_a     = R4_SELECTOR;
      @(negedge clk);
      bus.req_op    = OP_LDI;
      bus.req_a     = R4_SELECTOR;
      bus.req_imm   = 8'h00;
      check_output("busy_ignore_ready", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check_output("busy_rd_done", {31'd0, bus.done},     32'd1);
      check_output("busy_rd_rsp",  {24'd0, bus.rsp_data}, 32'h7E);
      apply_stimulus(OP_RD, R4_SELECTOR, R0_SELECTOR, 8'h00, lat, rsp, wec);
      check_output("busy_r4_kept", {24'd0, rsp}, 32'h7E);

      // Reset in the middle of a swap (WR_A cycle).
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_SWP;
      bus.req_a     = R2_SELECTOR;
      bus.req_b     = R5_SELECTOR;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_output("abort_wr_a_we", {31'd0, bus.dest_we}, 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check_output("abort_we_async", {31'd0, bus.dest_we}, 32'd0);
      check_output("abort_done",     {31'd0, bus.done},    32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_output("abort_ready", {31'd0, bus.req_ready}, 32'd1);
      check_output("abort_busy",  {31'd0, bus.busy},      32'd0);
      apply_stimulus(OP_LDI, R6_SELECTOR, R0_SELECTOR, 8'h96, lat, rsp, wec);
      apply_stimulus(OP_RD,  R6_SELECTOR, R0_SELECTOR, 8'h00, lat, rsp, wec);
      check_output("recover_rd_lat", lat, 2);
      check_output("recover_rd_rsp", {24'd0, rsp}, 32'h96);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
